reg_bank: RTL



---
 rtl/reg_bank_pkg.sv | 7 +
 rtl/mux_n1.sv | 18 +
 rtl/reg_bank.sv | 73 +++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared defaults, R0 index and word type for the register bank
package reg_bank_pkg;
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;
  localparam int R0 = 0;
  typedef logic [DEFAULT_WIDTH-1:0] reg_word_t;
endpackage

// File: rtl/mux_n1.sv
// mux_n1: generic N:1 selector over a flattened bus; out-of-range selects yield zero
module mux_n1
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N = DEFAULT_DEPTH,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++)
      if (sel == SEL_W'(i)) dout = din[i*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/reg_bank.sv
// reg_bank: parametrised register bank, one write port and two registered read ports.
// Define REG_BANK_BYPASS_EN for write-first forwarding on same-address collisions.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [WIDTH-1:0]  rdata_a,
  output logic              rvalid_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              rvalid_b,
  output logic              werr
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] flat;
  logic [WIDTH-1:0] mux_a, mux_b;
  logic wr_ok, fwd_a, fwd_b;

  assign wr_ok = we && ({1'b0, waddr} < (ADDR_W+1)'(DEPTH)) &&
                 !(ZERO_REG && waddr == ADDR_W'(R0));

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign flat[g*WIDTH +: WIDTH] = (ZERO_REG && g == R0) ? '0 : mem[g];
  end

`ifdef REG_BANK_BYPASS_EN
  assign fwd_a = wr_ok && waddr == raddr_a;
  assign fwd_b = wr_ok && waddr == raddr_b;
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  mux_n1 #(.WIDTH(WIDTH), .N(DEPTH), .SEL_W(ADDR_W)) u_mux_a (.din(flat), .sel(raddr_a), .dout(mux_a));
  mux_n1 #(.WIDTH(WIDTH), .N(DEPTH), .SEL_W(ADDR_W)) u_mux_b (.din(flat), .sel(raddr_b), .dout(mux_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_ok && waddr == ADDR_W'(i)) mem[i] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a  <= '0;
      rdata_b  <= '0;
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
      werr     <= 1'b0;
    end else begin
      rvalid_a <= re_a;
      rvalid_b <= re_b;
      werr     <= we && !wr_ok;
      if (re_a) rdata_a <= fwd_a ? wdata : mux_a;
      if (re_b) rdata_b <= fwd_b ? wdata : mux_b;
    end
  end
endmodule
